detect_event_counter: RTL and testbench
=======================================

DETECT_EVENT_COUNTER -- requirements
Module: detect_event_counter

Interface
REQ-001 SHALL have parameter WRAP, default 1: 1 = count wraps 99->00; 0 = count saturates at 99.
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 = tens digit blanked when zero; 0 = tens digit shows "0".
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port det  input  1  level output of the upstream sequence detector, synchronous to clk.
REQ-006 SHALL have port clr  input  1  synchronous clear of count and overflow flag.
REQ-007 SHALL have port hold  input  1  freeze; rising edges of det seen while high are dropped.
REQ-008 SHALL have port pulse  output  1  registered one-cycle strobe per counted detection.
REQ-009 SHALL have port cnt_ones  output  4  BCD ones digit of count.
REQ-010 SHALL have port cnt_tens  output  4  BCD tens digit of count.
REQ-011 SHALL have port ovf  output  1  sticky flag: increment attempted at count 99.
REQ-012 SHALL have port seg0  output  7  ones-digit 7-segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-013 SHALL have port seg1  output  7  tens-digit 7-segment drive, same encoding as seg0.

Function
REQ-014 SHALL register det into det_q on every clock edge, regardless of hold and clr.
REQ-015 SHALL define rise = det AND NOT det_q; a det level held high for N cycles yields exactly one rise.
REQ-016 SHALL, at an edge where rise=1, hold=0 and clr=0, increment the count and set pulse=1 for exactly that following cycle.
REQ-017 SHALL drive pulse=0 in every cycle not covered by REQ-016.
REQ-018 SHALL have 1-cycle latency: the count and pulse outputs change at the same edge that samples the rise.
REQ-019 SHALL keep the count in BCD: ones 9->0 with tens+1; ones/tens values 10-15 are never produced.
REQ-020 SHALL, on an increment at 99 with WRAP=1, load 00 and set ovf=1.
REQ-021 SHALL, on an increment at 99 with WRAP=0, keep 99, set ovf=1 and still assert pulse.
REQ-022 SHALL keep ovf set until clr or reset.
REQ-023 SHALL give clr priority: at a clr=1 edge, count:=00, ovf:=0, pulse:=0, and any simultaneous rise is dropped.
REQ-024 SHALL, for a rise with hold=1, not count it and not defer it; det_q still updates, so releasing hold while det stays high does not count.
REQ-025 SHALL decode seg0/seg1 combinationally from the count registers: 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h.
REQ-026 SHALL drive seg1=7Fh (all off) when BLANK_LZ=1 and cnt_tens=0; otherwise seg1 = decode of cnt_tens.

Reset
REQ-027 SHALL, while reset=1, asynchronously force det_q=0, count=00, ovf=0 and pulse=0, independent of clk.
REQ-028 SHALL show seg0=40h and seg1=7Fh (BLANK_LZ=1) during and after reset.
REQ-029 SHALL, if det=1 at the first edge after reset release, treat it as a rise and count it.
REQ-030 SHALL abort any in-flight pulse when reset is asserted mid-cycle; pulse reads 0 immediately.

Verification
REQ-031 SHALL cover: reset, then det high for 5 cycles -> one pulse; count 01; seg0=79h; seg1=7Fh.
REQ-032 SHALL cover: 12 separate det pulses of 1 cycle high and 1 cycle low -> 12 pulses; cnt_tens=1, cnt_ones=2; seg1=79h, seg0=24h.
REQ-033 SHALL cover: count 99 with WRAP=1, one rise -> count 00, ovf=1, pulse=1; with WRAP=0 -> count 99, ovf=1, pulse=1.
REQ-034 SHALL cover: rise coincident with clr=1 at count 07 -> count 00, ovf=0, pulse stays 0.
REQ-035 SHALL cover: hold=1 across a det rise, hold released while det still high -> count unchanged, no pulse; next fresh rise -> +1.
REQ-036 SHALL cover: reset asserted asynchronously between clock edges at count 45 with ovf=1 -> count 00, ovf=0, pulse=0 before the next edge.

Source files
------------

// File: rtl/detect_event_counter.sv
// Counts rising edges of an upstream detector level into a two-digit BCD count,
// with a sticky overflow flag, a per-count strobe and 7-segment digit drives.
module detect_event_counter #(
  parameter bit WRAP     = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det,
  input  logic       clr,
  input  logic       hold,
  output logic       pulse,
  output logic [3:0] cnt_ones,
  output logic [3:0] cnt_tens,
  output logic       ovf,
  output logic [6:0] seg0,
  output logic [6:0] seg1
);

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-BCD codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic       det_q;
  logic       pulse_q, pulse_d;
  logic       ovf_q, ovf_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       rise_s;

  assign rise_s = det & ~det_q;

  // Next-state: clear wins, then a non-held rise increments the BCD count.
  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
      ovf_d  = 1'b0;
    end else if (rise_s && !hold) begin
      pulse_d = 1'b1;
      if (ones_q == 4'd9 && tens_q == 4'd9) begin
        ovf_d = 1'b1;
        if (WRAP) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
        end else begin
          ones_d = ones_q;
          tens_d = tens_q;
        end
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      pulse_d = 1'b0;
    end
  end

  // State registers; det_q tracks det even while held or cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_q   <= 1'b0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      det_q   <= det;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  assign pulse    = pulse_q;
  assign ovf      = ovf_q;
  assign cnt_ones = ones_q;
  assign cnt_tens = tens_q;
  assign seg0     = seg_decode(ones_q);
  assign seg1     = (BLANK_LZ && tens_q == 4'd0) ? 7'h7F : seg_decode(tens_q);

endmodule

// File: tb/tb_detect_event_counter.sv
// Directed bench: a wrapping/blanking instance and a saturating/unblanked
// instance driven by the same inputs, checked against hand-computed values.
module tb_detect_event_counter;

  logic       clk;
  logic       reset;
  logic       det;
  logic       clr;
  logic       hold;
  logic       pulse, s_pulse;
  logic [3:0] cnt_ones, s_ones;
  logic [3:0] cnt_tens, s_tens;
  logic       ovf, s_ovf;
  logic [6:0] seg0, s_seg0;
  logic [6:0] seg1, s_seg1;

  int checks_q;
  int errors_q;
  int tally_q;

  detect_event_counter #(.WRAP(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .det(det), .clr(clr), .hold(hold),
    .pulse(pulse), .cnt_ones(cnt_ones), .cnt_tens(cnt_tens), .ovf(ovf),
    .seg0(seg0), .seg1(seg1)
  );

  detect_event_counter #(.WRAP(1'b0), .BLANK_LZ(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .det(det), .clr(clr), .hold(hold),
    .pulse(s_pulse), .cnt_ones(s_ones), .cnt_tens(s_tens), .ovf(s_ovf),
    .seg0(s_seg0), .seg1(s_seg1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_q++;
    if (obs !== exp) begin
      errors_q++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 1-high/1-low det pulse; tallies strobes seen on the wrapping instance.
  task automatic det_pulse();
    det = 1'b1;
    step();
    if (pulse) tally_q++;
    det = 1'b0;
    step();
    if (pulse) tally_q++;
  endtask

  initial begin
    checks_q = 0;
    errors_q = 0;
    tally_q  = 0;
    reset = 1'b1;
    det   = 1'b0;
    clr   = 1'b0;
    hold  = 1'b0;

    #3;
    check_val("rst_pulse", {31'd0, pulse}, 32'd0);
    check_val("rst_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    check_val("rst_ovf", {31'd0, ovf}, 32'd0);
    check_val("rst_seg0", {25'd0, seg0}, 32'h40);
    check_val("rst_seg1", {25'd0, seg1}, 32'h7F);
    check_val("rst_sat_seg1", {25'd0, s_seg1}, 32'h40);
    step();
    reset = 1'b0;
    step();

    // det high for 5 cycles -> exactly one count
    det = 1'b1;
    step();
    check_val("long_pulse1", {31'd0, pulse}, 32'd1);
    check_val("long_count", {24'd0, cnt_tens, cnt_ones}, 32'h01);
    check_val("long_seg0", {25'd0, seg0}, 32'h79);
    check_val("long_seg1", {25'd0, seg1}, 32'h7F);
    tally_q = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pulse) tally_q++;
    end
    check_val("long_no_more", tally_q, 32'd0);
    check_val("long_count_hold", {24'd0, cnt_tens, cnt_ones}, 32'h01);
    det = 1'b0;
    step();

    // clear, then 12 separate pulses
    clr = 1'b1;
    step();
    check_val("clr_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    clr = 1'b0;
    tally_q = 0;
    for (int i = 0; i < 12; i++) det_pulse();
    check_val("twelve_pulses", tally_q, 32'd12);
    check_val("twelve_tens", {28'd0, cnt_tens}, 32'd1);
    check_val("twelve_ones", {28'd0, cnt_ones}, 32'd2);
    check_val("twelve_seg1", {25'd0, seg1}, 32'h79);
    check_val("twelve_seg0", {25'd0, seg0}, 32'h24);

    // count 07, then rise together with clr
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) det_pulse();
    check_val("seven_count", {24'd0, cnt_tens, cnt_ones}, 32'h07);
    check_val("seven_seg0", {25'd0, seg0}, 32'h78);
    det = 1'b1;
    clr = 1'b1;
    step();
    check_val("clrrise_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    check_val("clrrise_pulse", {31'd0, pulse}, 32'd0);
    check_val("clrrise_ovf", {31'd0, ovf}, 32'd0);
    clr = 1'b0;
    step();
    check_val("clrrise_nodefer", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    det = 1'b0;
    step();

    // hold across a rise, release while det still high
    hold = 1'b1;
    det  = 1'b1;
    step();
    check_val("hold_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    check_val("hold_pulse", {31'd0, pulse}, 32'd0);
    hold = 1'b0;
    step();
    check_val("unhold_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    check_val("unhold_pulse", {31'd0, pulse}, 32'd0);
    det = 1'b0;
    step();
    det = 1'b1;
    step();
    check_val("fresh_count", {24'd0, cnt_tens, cnt_ones}, 32'h01);
    check_val("fresh_pulse", {31'd0, pulse}, 32'd1);
    det = 1'b0;
    step();

    // drive both instances to 99, then one more rise
    for (int i = 0; i < 98; i++) det_pulse();
    check_val("c99_count", {24'd0, cnt_tens, cnt_ones}, 32'h99);
    check_val("c99_sat_count", {24'd0, s_tens, s_ones}, 32'h99);
    check_val("c99_ovf", {31'd0, ovf}, 32'd0);
    det = 1'b1;
    step();
    check_val("wrap_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    check_val("wrap_ovf", {31'd0, ovf}, 32'd1);
    check_val("wrap_pulse", {31'd0, pulse}, 32'd1);
    check_val("wrap_seg1", {25'd0, seg1}, 32'h7F);
    check_val("sat_count", {24'd0, s_tens, s_ones}, 32'h99);
    check_val("sat_ovf", {31'd0, s_ovf}, 32'd1);
    check_val("sat_pulse", {31'd0, s_pulse}, 32'd1);
    det = 1'b0;
    step();
    check_val("ovf_sticky", {31'd0, ovf}, 32'd1);
    check_val("pulse_one_cycle", {31'd0, pulse}, 32'd0);
    det = 1'b1;
    step();
    check_val("sat_again_count", {24'd0, s_tens, s_ones}, 32'h99);
    check_val("sat_again_pulse", {31'd0, s_pulse}, 32'd1);
    check_val("wrap_next", {24'd0, cnt_tens, cnt_ones}, 32'h01);
    det = 1'b0;
    step();

    // reach 45 with a pulse in flight, then async reset mid-cycle
    for (int i = 0; i < 43; i++) det_pulse();
    det = 1'b1;
    step();
    check_val("c45_count", {24'd0, cnt_tens, cnt_ones}, 32'h45);
    check_val("c45_ovf", {31'd0, ovf}, 32'd1);
    check_val("c45_pulse", {31'd0, pulse}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    check_val("arst_ovf", {31'd0, ovf}, 32'd0);
    check_val("arst_pulse", {31'd0, pulse}, 32'd0);
    check_val("arst_seg0", {25'd0, seg0}, 32'h40);
    check_val("arst_seg1", {25'd0, seg1}, 32'h7F);
    step();
    check_val("rst_held_count", {24'd0, cnt_tens, cnt_ones}, 32'h00);
    reset = 1'b0;
    step();
    check_val("post_rst_rise", {24'd0, cnt_tens, cnt_ones}, 32'h01);
    check_val("post_rst_pulse", {31'd0, pulse}, 32'd1);
    det = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

endmodule
